// File: rtl/comparison_operand_loader_if.sv
// Bus between the switch/key front panel and the comparison operand loader.
// The loader takes the slave side; the board (or a bench) drives the master side.
interface comparison_operand_loader_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sw;
    logic             load_key;
    logic             clear_key;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             en;
    logic [1:0]       state;
    logic [3:0]       pair_count;

    modport master (
        output sw, load_key, clear_key,
        input  x, y, en, state, pair_count
    );

    modport slave (
        input  sw, load_key, clear_key,
        output x, y, en, state, pair_count
    );
endinterface

// File: rtl/comparison_operand_loader.sv
// Operand loader for the 4-bit comparison units.
// Captures x then y from the switches on debounced key presses, holds the pair
// and raises en while it is complete, and counts completed pairs (mod 16).
// Optional macro LOADER_DEBOUNCE_EN: when defined, each key level must be
// stable for DEBOUNCE_CYCLES cycles before it is accepted; when undefined the
// synchronized level is used directly.
module comparison_operand_loader #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input logic                       clk,
    input logic                       rst,
    comparison_operand_loader_if.slave bus
);
    typedef enum logic [1:0] {
        S_X     = 2'b00,
        S_Y     = 2'b01,
        S_READY = 2'b10
    } state_t;

    // Key index 0 is load, index 1 is clear.
    logic [1:0] key_raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] deb;
    logic [1:0] deb_q;
    logic [1:0] armed;
    logic [1:0] ev;
    logic [1:0] primed;
    logic       load_ev;
    logic       clear_ev;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             en_q, en_d;
    logic [3:0]       cnt_q, cnt_d;

    assign key_raw = {bus.clear_key, bus.load_key};

    // Two-flop synchronizer for both raw keys.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

`ifdef LOADER_DEBOUNCE_EN
    logic [CNT_W-1:0] db_cnt [2];

    // Flip the debounced level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb <= '0;
            for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] != deb[k]) begin
                    if (db_cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb[k]    <= sync2[k];
                        db_cnt[k] <= '0;
                    end else begin
                        db_cnt[k] <= db_cnt[k] + 1'b1;
                    end
                end else begin
                    db_cnt[k] <= '0;
                end
            end
        end
    end
`else
    // Without debouncing the debounce settings have no effect.
    logic [CNT_W-1:0] unused_db_limit;
    assign unused_db_limit = CNT_W'(DEBOUNCE_CYCLES);
    assign deb = sync2;
`endif

    // Rising-edge detect; a key is armed only once it has been seen released
    // after reset, so a key held through reset cannot fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed <= '0;
            deb_q  <= '0;
            armed  <= '0;
            ev     <= '0;
        end else begin
            primed <= {primed[0], 1'b1};
            deb_q  <= deb;
            for (int k = 0; k < 2; k++) begin
                if (primed[1] && !sync2[k] && !deb[k]) armed[k] <= 1'b1;
                ev[k] <= armed[k] & deb[k] & ~deb_q[k];
            end
        end
    end

    assign load_ev  = ev[0];
    assign clear_ev = ev[1];

    // Operand FSM next state and outputs; clear has priority over load.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        en_d    = en_q;
        cnt_d   = cnt_q;
        if (clear_ev) begin
            state_d = S_X;
            x_d     = '0;
            y_d     = '0;
            en_d    = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_X: begin
                    if (load_ev) begin
                        x_d     = bus.sw;
                        state_d = S_Y;
                    end
                end
                S_Y: begin
                    if (load_ev) begin
                        y_d     = bus.sw;
                        en_d    = 1'b1;
                        cnt_d   = cnt_q + 4'd1;
                        state_d = S_READY;
                    end
                end
                S_READY: begin
                    if (load_ev) begin
                        x_d     = bus.sw;
                        en_d    = 1'b0;
                        state_d = S_Y;
                    end
                end
                default: begin
                    state_d = S_X;
                    x_d     = '0;
                    y_d     = '0;
                    en_d    = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, operands, en and pair count all move on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_X;
            x_q     <= '0;
            y_q     <= '0;
            en_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.en         = en_q;
    assign bus.state      = state_q;
    assign bus.pair_count = cnt_q;
endmodule

// File: tb/tb_comparison_operand_loader.sv
// Bench for comparison_operand_loader with DEBOUNCE_CYCLES = 4.
// Expected output snapshots are queued as keys are pressed and matched
// whenever the DUT outputs change.
module tb_comparison_operand_loader;
    localparam int DB = 4;
`ifdef LOADER_DEBOUNCE_EN
    localparam int LAT           = 2 + DB + 1;
    localparam int BOUNCE_EVENTS = 1;
`else
    localparam int LAT           = 3;
    localparam int BOUNCE_EVENTS = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    comparison_operand_loader_if #(.WIDTH(4)) bus ();

    comparison_operand_loader #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       en;
        logic [1:0] st;
        logic [3:0] cnt;
    } snap_t;

    typedef struct {
        logic [3:0] sw;
        snap_t      exp;
    } vec_t;

    snap_t exp_q[$];
    snap_t prev;
    snap_t m;
    int    tests = 0;
    int    fails = 0;
    vec_t  vecs[4];

    function automatic snap_t dut_snap();
        snap_t s;
        s.x   = bus.x;
        s.y   = bus.y;
        s.en  = bus.en;
        s.st  = bus.state;
        s.cnt = bus.pair_count;
        return s;
    endfunction

    task automatic check_snap(input string name, input snap_t act, input snap_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got x=%0d y=%0d en=%0d state=%0d cnt=%0d, want x=%0d y=%0d en=%0d state=%0d cnt=%0d",
                     name, act.x, act.y, act.en, act.st, act.cnt, exp.x, exp.y, exp.en, exp.st, exp.cnt);
        end
    endtask

    task automatic model_load(input logic [3:0] swv);
        case (m.st)
            2'd0: begin m.x = swv; m.st = 2'd1; end
            2'd1: begin m.y = swv; m.st = 2'd2; m.en = 1'b1; m.cnt = m.cnt + 4'd1; end
            default: begin m.x = swv; m.st = 2'd1; m.en = 1'b0; end
        endcase
        exp_q.push_back(m);
    endtask

    task automatic model_clear();
        m = '0;
        exp_q.push_back(m);
    endtask

    task automatic press(input logic [3:0] swv, input logic ld, input logic cl,
                         input int hold, input int rel);
        @(posedge clk); #1;
        bus.sw        = swv;
        bus.load_key  = ld;
        bus.clear_key = cl;
        repeat (hold) @(posedge clk);
        #1;
        bus.load_key  = 1'b0;
        bus.clear_key = 1'b0;
        repeat (rel) @(posedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d expected updates outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        bus.sw        = '0;
        bus.load_key  = 1'b0;
        bus.clear_key = 1'b0;
        m             = '0;

        vecs[0] = '{sw: 4'd5,  exp: '{x: 4'd5, y: 4'd0,  en: 1'b0, st: 2'd1, cnt: 4'd0}};
        vecs[1] = '{sw: 4'd9,  exp: '{x: 4'd5, y: 4'd9,  en: 1'b1, st: 2'd2, cnt: 4'd1}};
        vecs[2] = '{sw: 4'd3,  exp: '{x: 4'd3, y: 4'd9,  en: 1'b0, st: 2'd1, cnt: 4'd1}};
        vecs[3] = '{sw: 4'd12, exp: '{x: 4'd3, y: 4'd12, en: 1'b1, st: 2'd2, cnt: 4'd2}};

        // Scoreboard monitor: every output change must match the next queued snapshot.
        fork
            forever begin
                snap_t cur;
                snap_t e;
                @(negedge clk);
                cur = dut_snap();
                if (rst) begin
                    prev = cur;
                end else if (cur != prev) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_change: got x=%0d y=%0d en=%0d state=%0d cnt=%0d, want no change",
                                 cur.x, cur.y, cur.en, cur.st, cur.cnt);
                    end else begin
                        e = exp_q.pop_front();
                        check_snap("scoreboard", cur, e);
                    end
                    prev = cur;
                end
            end
        join_none

        // Reset, then idle.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_snap("reset_idle", dut_snap(), '0);

        // First press: exact press-to-update latency.
        exp_q.push_back(vecs[0].exp);
        @(posedge clk); #1;
        bus.sw       = vecs[0].sw;
        bus.load_key = 1'b1;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        check_snap("before_first_event", dut_snap(), '0);
        @(posedge clk);
        @(negedge clk);
        check_snap("first_event", dut_snap(), vecs[0].exp);
        repeat (20 - LAT - 1) @(posedge clk);
        #1 bus.load_key = 1'b0;
        repeat (20) @(posedge clk);
        drain();

        // Remaining table rows: complete pair, reload x from READY, complete again.
        for (int i = 1; i < 4; i++) begin
            exp_q.push_back(vecs[i].exp);
            press(vecs[i].sw, 1'b1, 1'b0, 20, 20);
            drain();
        end
        m = vecs[3].exp;

        // Bouncing load key: 1,0,1,0 for 2 cycles each, then held high.
        for (int i = 0; i < BOUNCE_EVENTS; i++) model_load(4'd7);
        @(posedge clk); #1;
        bus.sw = 4'd7;
        for (int i = 0; i < 4; i++) begin
            bus.load_key = ~bus.load_key;
            repeat (2) @(posedge clk);
            #1;
        end
        bus.load_key = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus.load_key = 1'b0;
        repeat (20) @(posedge clk);
        drain();
        @(negedge clk);
        check_snap("bounce_final", dut_snap(), m);

        // Clear alone.
        model_clear();
        press(4'd0, 1'b0, 1'b1, 12, 20);
        drain();

        // Sixteen complete pairs: count wraps to 0 with en still high.
        for (int i = 0; i < 32; i++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            model_load(r);
            press(r, 1'b1, 1'b0, 12, 12);
            drain();
        end
        @(negedge clk);
        tests++;
        if ({bus.en, bus.state, bus.pair_count} !== 7'b1_10_0000) begin
            fails++;
            $display("FAIL pair_wrap: got en=%0d state=%0d cnt=%0d, want en=1 state=2 cnt=0",
                     bus.en, bus.state, bus.pair_count);
        end

        // Load and clear in the same cycle: clear wins.
        model_clear();
        press(4'hA, 1'b1, 1'b1, 12, 20);
        drain();
        @(negedge clk);
        check_snap("clear_wins", dut_snap(), '0);

        // Reset mid-debounce with the key still held afterwards.
        @(posedge clk); #1;
        bus.sw       = 4'd6;
        bus.load_key = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_snap("held_after_reset", dut_snap(), '0);
        #1 bus.load_key = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_snap("released_after_reset", dut_snap(), '0);
        m = '0;
        model_load(4'd6);
        press(4'd6, 1'b1, 1'b0, 12, 20);
        drain();
        @(negedge clk);
        check_snap("rearmed_load", dut_snap(), '{x: 4'd6, y: 4'd0, en: 1'b0, st: 2'd1, cnt: 4'd0});

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/comparison_operand_loader.md
Name: comparison_operand_loader

Overview:
- Upstream stage of the 4-bit comparison units (equal / greater / less / max). Captures operand x, then operand y, from the board switches on debounced key presses.
- Holds both operands stable and asserts en to the comparators while the pair is complete.
- Counts completed operand pairs for LED display.

Parameters:
- WIDTH, 4, operand width in bits (sw, x, y).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a key level is accepted. Benches override this to 4.
- CNT_W, 16, width of the internal debounce counter. Must hold DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- sw  input  WIDTH  operand value from switches, sampled on a load event
- load_key  input  1  raw load button, active-high, asynchronous to clk
- clear_key  input  1  raw clear button, active-high, asynchronous to clk
- x  output  WIDTH  latched operand x to the comparators
- y  output  WIDTH  latched operand y to the comparators
- en  output  1  high while x/y form a complete, stable pair
- state  output  2  FSM state for LEDs: 00 = S_X, 01 = S_Y, 10 = S_READY
- pair_count  output  4  number of completed pairs, wraps

Behaviour:
- Reset (async assert, released on clock edge):
  - state = S_X; x = 0, y = 0, en = 0, pair_count = 0.
  - Synchronizers, debounce counters and debounced levels = 0.
- Input path, per key:
  - Two-flop synchronizer, then debounce (see Optional Feature), then rising-edge detect.
  - Output is a one-cycle event pulse: load_ev or clear_ev.
  - Holding a key produces exactly one event. Release produces none.
- FSM, all registers update on the clock edge after the event pulse:
  - S_X + load_ev: x <= sw; go to S_Y.
  - S_Y + load_ev: y <= sw; go to S_READY; en <= 1; pair_count <= pair_count + 1, modulo 16 (15 -> 0).
  - S_READY + load_ev: x <= sw; y holds; en <= 0; go to S_Y (start of a new pair).
  - Any state + clear_ev: go to S_X; x = 0, y = 0, en = 0, pair_count = 0.
  - clear_ev and load_ev in the same cycle: clear wins and sw is ignored.
  - No event: all outputs hold.
- en is registered. en == 1 exactly when state == S_READY.
- x and y never change while en == 1 except through a load_ev or clear_ev, which drops en in the same cycle the operand changes.
- Comparators see no glitch: en and the operands update on the same edge.
- The unused state encoding 11 returns to S_X on the next clock with x, y, en and pair_count cleared.
- Reset asserted mid-debounce or mid-pair aborts everything. A key still held after reset release must first read released (debounced 0) before it can generate an event.

Optional Feature:
- Macro: LOADER_DEBOUNCE_EN.
- Defined:
  - Synchronized level must differ from the current debounced level for DEBOUNCE_CYCLES consecutive cycles before the debounced level flips.
  - Any return to the old value restarts the counter at 0.
  - Press-to-event latency = 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) cycles.
- Undefined:
  - Counter logic removed; debounced level = synchronized level.
  - Press-to-event latency = 3 cycles. Bounces generate multiple events.
  - DEBOUNCE_CYCLES and CNT_W are ignored.

Test Plan (macro defined, DEBOUNCE_CYCLES=4):
- Reset then idle 10 cycles -> x=0, y=0, en=0, state=00, pair_count=0.
- sw=5, hold load_key 20 cycles; sw=9, hold load_key 20 cycles -> first event at cycle 7 after press gives x=5, state=01; second gives y=9, en=1, state=10, pair_count=1.
- Load key bounce 1,0,1,0 with each level held 2 cycles, then held high 10 cycles -> exactly one load_ev; x updated once.
- In S_READY (x=5, y=9) with sw=3, press load -> x=3, y=9, en=0, state=01. Next press with sw=12 -> y=12, en=1, pair_count=2.
- Complete 16 pairs -> pair_count wraps to 0 on the 16th, en=1. Then load and clear events in the same cycle -> state=00, x=y=0, en=0, pair_count=0.
- Assert rst while load_key is held mid-debounce, release rst with key still held -> no event until the key is released and pressed again. Outputs stay at reset values.
